// File: rtl/pixel_serializer_pkg.sv
// Shared encodings, line FSM states and mode helpers for pixel_serializer.
package pixel_serializer_pkg;

  localparam logic [1:0] BPP_1 = 2'b00;
  localparam logic [1:0] BPP_2 = 2'b01;
  localparam logic [1:0] BPP_4 = 2'b10;

  localparam logic [1:0] SCALE_1 = 2'b00;
  localparam logic [1:0] SCALE_2 = 2'b01;
  localparam logic [1:0] SCALE_4 = 2'b10;
  localparam logic [1:0] SCALE_8 = 2'b11;

  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;

  // Mode 11 is reserved and behaves as 2bpp.
  function automatic int bpp_of(input logic [1:0] mode);
    case (mode)
      BPP_1:   return 1;
      BPP_2:   return 2;
      BPP_4:   return 4;
      default: return 2;
    endcase
  endfunction

  function automatic int slots_of(input logic [1:0] mode, input int data_w);
    return data_w / bpp_of(mode);
  endfunction

endpackage

// File: rtl/pixser_hold_buf.sv
// One-entry valid/ready holding register between the VRAM fetch sequencer
// and the pixel shifter; flush empties it and blocks acceptance that cycle.
module pixser_hold_buf #(
  parameter int DATA_W = 8
) (
  input  logic              pixel_clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              take,
  output logic              full,
  output logic [DATA_W-1:0] data
);

  assign in_ready = ~full & ~flush;

  // take only happens while full, and in_ready is low while full, so the
  // two never collide.
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      full <= 1'b0;
      data <= '0;
    end else if (flush) begin
      full <= 1'b0;
      data <= '0;
    end else if (take) begin
      full <= 1'b0;
    end else if (in_valid && in_ready) begin
      full <= 1'b1;
      data <= in_data;
    end
  end

endmodule

// File: rtl/pixel_serializer.sv
// VRAM-byte to palette-index serializer (1/2/4 bpp, 1..8x horizontal repeat).
// Optional PIXEL_SERIALIZER_UNDERRUN_CNT_EN adds a saturating underrun_cnt.
module pixel_serializer
  import pixel_serializer_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int IDX_W      = 4,
  parameter int BG_DEFAULT = 0
) (
  input  logic              pixel_clock,
  input  logic              reset,
  input  logic              line_start,
  input  logic              active,
  input  logic [1:0]        bpp_mode,
  input  logic [1:0]        scale_sel,
  input  logic              code_valid,
  input  logic [DATA_W-1:0] pixel_code,
  output logic              code_ready,
  output logic [IDX_W-1:0]  pixel_bit,
  output logic              pixel_valid,
  output logic              underrun
`ifdef PIXEL_SERIALIZER_UNDERRUN_CNT_EN
  ,
  output logic [15:0]       underrun_cnt
`endif
);

  localparam int SLOT_W = $clog2(DATA_W + 1);
  localparam logic [IDX_W-1:0] BG_IDX = IDX_W'(BG_DEFAULT);
  localparam logic [SLOT_W-1:0] SLOTS_1 = SLOT_W'(slots_of(BPP_1, DATA_W));
  localparam logic [SLOT_W-1:0] SLOTS_2 = SLOT_W'(slots_of(BPP_2, DATA_W));
  localparam logic [SLOT_W-1:0] SLOTS_4 = SLOT_W'(slots_of(BPP_4, DATA_W));

  state_t            state, state_next;
  logic [1:0]        bpp_q, scale_q;
  logic [DATA_W-1:0] shift_reg, hold_data, cur;
  logic [SLOT_W-1:0] slot_cnt, slot_base, slot_load;
  logic [2:0]        rep_cnt, rep_last, shift_by;
  logic              hold_full, produce, need_load, do_load, starve;
  logic              rep_wrap, emit_bg;
  logic [3:0]        top4;
  logic [IDX_W-1:0]  cur_idx;

  pixser_hold_buf #(.DATA_W(DATA_W)) u_hold (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .flush       (line_start),
    .in_valid    (code_valid),
    .in_data     (pixel_code),
    .in_ready    (code_ready),
    .take        (do_load),
    .full        (hold_full),
    .data        (hold_data)
  );

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (line_start) begin
      state_next = ARMED;
    end else begin
      case (state)
        ARMED:   if (active)  state_next = RUN;
        RUN:     if (!active) state_next = DONE;
        default: state_next = state;
      endcase
    end
  end

  // The first active cycle after ARMED already emits a pixel.
  assign produce   = active && !line_start && (state == ARMED || state == RUN);
  assign need_load = (slot_cnt == '0) && (rep_cnt == '0);
  assign do_load   = produce && need_load && hold_full;
  assign starve    = produce && need_load && !hold_full;
  assign rep_wrap  = (rep_cnt == rep_last);
  assign emit_bg   = (slot_cnt == '0) && !do_load;
  assign cur       = do_load ? hold_data : shift_reg;
  assign top4      = cur[DATA_W-1 -: 4];
  assign slot_base = do_load ? slot_load : slot_cnt;

  always_comb begin
    rep_last = 3'd0;
    case (scale_q)
      SCALE_1: rep_last = 3'd0;
      SCALE_2: rep_last = 3'd1;
      SCALE_4: rep_last = 3'd3;
      SCALE_8: rep_last = 3'd7;
      default: rep_last = 3'd0;
    endcase
  end

  always_comb begin
    cur_idx   = IDX_W'(top4[3:2]);
    shift_by  = 3'd2;
    slot_load = SLOTS_2;
    case (bpp_q)
      BPP_1: begin
        cur_idx   = IDX_W'(top4[3]);
        shift_by  = 3'd1;
        slot_load = SLOTS_1;
      end
      BPP_4: begin
        cur_idx   = IDX_W'(top4);
        shift_by  = 3'd4;
        slot_load = SLOTS_4;
      end
      default: begin
        cur_idx   = IDX_W'(top4[3:2]);
        shift_by  = 3'd2;
        slot_load = SLOTS_2;
      end
    endcase
  end

  // During an underrun slot slot_cnt stays 0 while rep_cnt runs, so the
  // load is retried exactly at the next slot boundary.
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      bpp_q       <= BPP_1;
      scale_q     <= SCALE_1;
      shift_reg   <= '0;
      slot_cnt    <= '0;
      rep_cnt     <= '0;
      underrun    <= 1'b0;
      pixel_valid <= 1'b0;
      pixel_bit   <= BG_IDX;
    end else if (line_start) begin
      bpp_q       <= bpp_mode;
      scale_q     <= scale_sel;
      shift_reg   <= '0;
      slot_cnt    <= '0;
      rep_cnt     <= '0;
      underrun    <= 1'b0;
      pixel_valid <= 1'b0;
      pixel_bit   <= BG_IDX;
    end else begin
      pixel_valid <= produce;
      pixel_bit   <= (produce && !emit_bg) ? cur_idx : BG_IDX;
      if (starve) underrun <= 1'b1;
      if (produce) begin
        rep_cnt <= rep_wrap ? 3'd0 : rep_cnt + 3'd1;
        if (do_load || slot_cnt != '0) begin
          shift_reg <= rep_wrap ? (cur << shift_by) : cur;
          slot_cnt  <= rep_wrap ? slot_base - 1'b1 : slot_base;
        end
      end
    end
  end

`ifdef PIXEL_SERIALIZER_UNDERRUN_CNT_EN
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset)                               underrun_cnt <= '0;
    else if (starve && underrun_cnt != '1)   underrun_cnt <= underrun_cnt + 16'd1;
  end
`endif

endmodule
